// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: prioritized PC/IF-ID/ID-EX write and flush
// controls from load-use, redirect, memory handshakes and MDU occupancy.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        J,
  input  logic        JR,
  input  logic        Z,
  input  logic        ImemReady,
  input  logic        DmemReady,
  input  logic        MduStart_id,
  input  logic        MduIsDiv_id,
  input  logic        MduUse_id,
  output logic        PC_IFWrite,
  output logic        IF_IDWrite,
  output logic        IF_IDFlush,
  output logic        ID_EXWrite,
  output logic        ID_EXFlush,
  output logic        MduBusy,
  output logic        MduDone,
  output logic [5:0]  MduCount,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t state, state_nxt;
  logic [5:0] count_nxt;
  logic       hz, redirect, advance;

  assign MduBusy  = (state != IDLE);
  assign MduDone  = (state == DONE);
  assign hz       = Stall | (MduUse_id & MduBusy);
  assign redirect = J | JR | Z;
  assign advance  = DmemReady & ~hz & ~reset;

  // Controls ordered by priority; first matching case wins.
  always_comb begin
    PC_IFWrite = 1'b1;
    IF_IDWrite = 1'b1;
    IF_IDFlush = 1'b0;
    ID_EXWrite = 1'b1;
    ID_EXFlush = 1'b0;
    if (reset) begin
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
      IF_IDFlush = 1'b1;
      ID_EXFlush = 1'b1;
    end else if (!DmemReady) begin
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
    end else if (hz) begin
      // branch operands are stale while stalled, so redirect is held off
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
    end else if (redirect) begin
      IF_IDFlush = 1'b1;
    end else if (!ImemReady) begin
      PC_IFWrite = 1'b0;
      IF_IDFlush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = MduCount;
    case (state)
      IDLE: if (MduStart_id && advance) begin
        state_nxt = BUSY;
        count_nxt = MduIsDiv_id ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
      end
      // counts down regardless of a memory freeze
      BUSY: if (MduCount == 6'd0) state_nxt = DONE;
            else count_nxt = MduCount - 6'd1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      MduCount   <= 6'd0;
      StallCount <= 32'd0;
    end else begin
      state    <= state_nxt;
      MduCount <= count_nxt;
      if (DmemReady && hz && StallCount != 32'hFFFF_FFFF)
        StallCount <= StallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default MDU latencies.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Stall = 0, J = 0, JR = 0, Z = 0, ImemReady = 1, DmemReady = 1;
  logic MduStart_id = 0, MduIsDiv_id = 0, MduUse_id = 0;
  logic PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush;
  logic MduBusy, MduDone;
  logic [5:0]  MduCount;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;

  // {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush}
  localparam logic [4:0] C_RST    = 5'b00101;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_HZ     = 5'b00011;
  localparam logic [4:0] C_REDIR  = 5'b11110;
  localparam logic [4:0] C_IMEM   = 5'b01110;
  localparam logic [4:0] C_NORM   = 5'b11010;

  wire [4:0] ctl = {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush};

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .Stall(Stall), .J(J), .JR(JR), .Z(Z),
    .ImemReady(ImemReady), .DmemReady(DmemReady),
    .MduStart_id(MduStart_id), .MduIsDiv_id(MduIsDiv_id), .MduUse_id(MduUse_id),
    .PC_IFWrite(PC_IFWrite), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
    .ID_EXWrite(ID_EXWrite), .ID_EXFlush(ID_EXFlush),
    .MduBusy(MduBusy), .MduDone(MduDone), .MduCount(MduCount), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_busy", 32'(MduBusy), 0);
    chk("rst_done", 32'(MduDone), 0);
    chk("rst_cnt", 32'(MduCount), 0);
    chk("rst_stall", StallCount, 0);
    tick();
    reset = 0;
    #1 chk("normal", 32'(ctl), 32'(C_NORM));

    // divide followed by a HI/LO reader
    MduStart_id = 1; MduIsDiv_id = 1;
    #1 chk("div_start_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    MduStart_id = 0; MduIsDiv_id = 0; MduUse_id = 1;
    #1;
    chk("div_busy0", 32'(MduBusy), 1);
    chk("div_cnt0", 32'(MduCount), 31);
    chk("div_hz_ctl", 32'(ctl), 32'(C_HZ));
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("div_cnt", 32'(MduCount), 32'(31 - k));
      chk("div_busy", 32'(MduBusy), 1);
      chk("div_nodone", 32'(MduDone), 0);
    end
    tick();
    chk("div_done", 32'(MduDone), 1);
    chk("div_done_busy", 32'(MduBusy), 1);
    chk("div_done_ctl", 32'(ctl), 32'(C_HZ));
    tick();
    chk("div_idle_busy", 32'(MduBusy), 0);
    chk("div_idle_done", 32'(MduDone), 0);
    chk("div_release_ctl", 32'(ctl), 32'(C_NORM));
    chk("div_stallcnt", StallCount, 33);
    MduUse_id = 0;

    // multiply in flight through a 3-cycle memory freeze
    MduStart_id = 1;
    tick();
    MduStart_id = 0;
    chk("mul_cnt0", 32'(MduCount), 3);
    DmemReady = 0; Stall = 1; J = 1;
    #1 chk("freeze_ctl", 32'(ctl), 32'(C_FREEZE));
    tick(); tick(); tick();
    chk("freeze_cnt", 32'(MduCount), 0);
    chk("freeze_stallcnt", StallCount, 33);
    chk("freeze_ctl2", 32'(ctl), 32'(C_FREEZE));
    DmemReady = 1; Stall = 0; J = 0;
    tick();
    chk("mul_done", 32'(MduDone), 1);
    tick();
    chk("mul_idle", 32'(MduBusy), 0);

    // load-use stall suppresses redirect, then redirect applies
    Stall = 1; Z = 1;
    #1 chk("lu_ctl", 32'(ctl), 32'(C_HZ));
    tick();
    chk("lu_stallcnt", StallCount, 34);
    Stall = 0;
    #1 chk("lu_redir_ctl", 32'(ctl), 32'(C_REDIR));
    Z = 0;

    // imem wait with and without redirect
    ImemReady = 0; JR = 1;
    #1 chk("imem_jr_ctl", 32'(ctl), 32'(C_REDIR));
    JR = 0;
    #1 chk("imem_wait_ctl", 32'(ctl), 32'(C_IMEM));
    ImemReady = 1;
    tick();

    // overlapping load-use and MDU stall counts once; reset at MduCount==2
    MduStart_id = 1;
    tick();
    MduStart_id = 0; Stall = 1; MduUse_id = 1;
    tick();
    chk("dual_stallcnt", StallCount, 35);
    chk("mul_cnt2", 32'(MduCount), 2);
    Stall = 0; MduUse_id = 0;
    reset = 1;
    #1;
    chk("rstmid_busy", 32'(MduBusy), 0);
    chk("rstmid_cnt", 32'(MduCount), 0);
    chk("rstmid_ctl", 32'(ctl), 32'(C_RST));
    tick();
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rstmid_nodone", 32'(MduDone), 0);
    end

    // saturation
    force dut.StallCount = 32'hFFFF_FFFD;
    #1 release dut.StallCount;
    Stall = 1;
    tick();
    chk("sat1", StallCount, 32'hFFFF_FFFE);
    tick();
    chk("sat2", StallCount, 32'hFFFF_FFFF);
    tick();
    chk("sat3", StallCount, 32'hFFFF_FFFF);
    Stall = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
